// File: rtl/alarm_clock_pkg.sv
// Shared alarm-clock constants: the "no key" code, the 4x3 keypad map and the column scan states.
package alarm_clock_pkg;

  localparam logic [3:0]  NOKEY    = 4'hA;
  localparam int unsigned NUM_COLS = 3;
  localparam int unsigned NUM_ROWS = 4;

  // Indexed [row][col]; '*' and '#' decode as NOKEY so they can never raise a strobe.
  localparam logic [3:0][2:0][3:0] KEY_MAP = {
    {4'hA, 4'h0, 4'hA},
    {4'h9, 4'h8, 4'h7},
    {4'h6, 4'h5, 4'h4},
    {4'h3, 4'h2, 4'h1}
  };

  typedef enum logic [1:0] {
    StCol0 = 2'd0,
    StCol1 = 2'd1,
    StCol2 = 2'd2
  } col_e;

  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = NOKEY;
    if ({30'd0, col} < NUM_COLS) begin
      code = KEY_MAP[row][col];
    end
    return code;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchroniser followed by a stability counter that only lets
// a level through after it has differed from the output for BTN_DEBOUNCE consecutive cycles.
module btn_debounce #(
  parameter int unsigned BTN_DEBOUNCE = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic btn_o
);

  localparam int unsigned     CntW    = (BTN_DEBOUNCE > 2) ? $clog2(BTN_DEBOUNCE) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(BTN_DEBOUNCE - 1);

  logic            meta_q;
  logic            sync_q;
  logic            level_q;
  logic            level_d;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = sync_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= btn_i;
      sync_q  <= meta_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign btn_o = level_q;

endmodule

// File: rtl/alarm_keypad_scanner.sv
// Alarm-clock input stage: scans a 4x3 keypad one column at a time, debounces the decoded key
// over whole scan frames, and conditions the time-set and alarm-set buttons.
module alarm_keypad_scanner
  import alarm_clock_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 16,
  parameter int unsigned DEBOUNCE_FRAMES = 4,
  parameter int unsigned BTN_DEBOUNCE    = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row_sense,
  output logic [2:0] col_drive,
  input  logic       time_button_raw,
  input  logic       alarm_button_raw,
  output logic [3:0] key,
  output logic       key_strobe,
  output logic       time_button,
  output logic       alarm_button
);

  localparam int unsigned       DwellW    = $clog2(SCAN_DIV);
  localparam int unsigned       StbW      = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DwellW-1:0] DwellLast = DwellW'(SCAN_DIV - 1);
  localparam logic [StbW-1:0]   StbFull   = StbW'(DEBOUNCE_FRAMES);

  logic [3:0]        row_meta_q;
  logic [3:0]        row_sync_q;
  col_e              col_q;
  col_e              col_d;
  logic [DwellW-1:0] dwell_q;
  logic [DwellW-1:0] dwell_d;
  logic [1:0]        hits_q;
  logic [1:0]        hits_d;
  logic [3:0]        code_q;
  logic [3:0]        code_d;
  logic [StbW-1:0]   stable_q;
  logic [StbW-1:0]   stable_d;
  logic [3:0]        prev_code_q;
  logic [3:0]        prev_code_d;
  logic [3:0]        key_q;
  logic [3:0]        key_d;
  logic              strobe_q;
  logic              strobe_d;

  logic              sample;
  logic              frame_close;
  logic [3:0]        row_act;
  logic [2:0]        col_hits;
  logic [1:0]        hit_row;
  logic [1:0]        base_hits;
  logic [3:0]        base_code;
  logic [2:0]        sum_hits;
  logic [1:0]        acc_hits;
  logic [3:0]        acc_code;
  logic [3:0]        frame_code;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      row_meta_q <= '0;
      row_sync_q <= '0;
    end else begin
      row_meta_q <= row_sense;
      row_sync_q <= row_meta_q;
    end
  end

  // Column scan: rows are only looked at on the last dwell cycle, once the synchroniser settled.
  always_comb begin
    sample      = (dwell_q == DwellLast);
    frame_close = sample && (col_q == StCol2);
    dwell_d     = sample ? '0 : dwell_q + DwellW'(1);
    col_d       = col_q;
    if (sample) begin
      unique case (col_q)
        StCol0:  col_d = StCol1;
        StCol1:  col_d = StCol2;
        default: col_d = StCol0;
      endcase
    end
  end

  assign col_drive = ~(3'b001 << col_q);

  // Frame accumulator: hit count saturates at 2, anything above one hit is a ghost or multi-press.
  always_comb begin
    row_act  = ~row_sync_q;
    col_hits = '0;
    hit_row  = '0;
    for (int unsigned r = 0; r < NUM_ROWS; r++) begin
      if (row_act[r]) begin
        col_hits = col_hits + 3'd1;
        hit_row  = 2'(r);
      end
    end
    base_hits  = (col_q == StCol0) ? 2'd0 : hits_q;
    base_code  = (col_q == StCol0) ? NOKEY : code_q;
    sum_hits   = {1'b0, base_hits} + col_hits;
    acc_hits   = (sum_hits >= 3'd2) ? 2'd2 : sum_hits[1:0];
    acc_code   = (col_hits == 3'd1) ? key_lookup(hit_row, col_q) : base_code;
    frame_code = (acc_hits == 2'd1) ? acc_code : NOKEY;
    hits_d     = sample ? acc_hits : hits_q;
    code_d     = sample ? acc_code : code_q;
  end

  // Frame debounce: the key only moves once DEBOUNCE_FRAMES identical frames have been seen,
  // judged on the updated count so the change lands on the closing edge of that frame.
  always_comb begin
    stable_d    = stable_q;
    prev_code_d = prev_code_q;
    key_d       = key_q;
    strobe_d    = 1'b0;
    if (frame_close) begin
      if (frame_code == prev_code_q) begin
        if (stable_q != StbFull) begin
          stable_d = stable_q + StbW'(1);
        end
      end else begin
        stable_d    = StbW'(1);
        prev_code_d = frame_code;
      end
      if ((stable_d == StbFull) && (frame_code != key_q)) begin
        key_d    = frame_code;
        strobe_d = (frame_code != NOKEY);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col_q       <= StCol0;
      dwell_q     <= '0;
      hits_q      <= '0;
      code_q      <= '0;
      stable_q    <= '0;
      prev_code_q <= NOKEY;
      key_q       <= NOKEY;
      strobe_q    <= 1'b0;
    end else begin
      col_q       <= col_d;
      dwell_q     <= dwell_d;
      hits_q      <= hits_d;
      code_q      <= code_d;
      stable_q    <= stable_d;
      prev_code_q <= prev_code_d;
      key_q       <= key_d;
      strobe_q    <= strobe_d;
    end
  end

  assign key        = key_q;
  assign key_strobe = strobe_q;

  btn_debounce #(
    .BTN_DEBOUNCE(BTN_DEBOUNCE)
  ) u_time_btn (
    .clk_i (clock),
    .rst_ni(reset),
    .btn_i (time_button_raw),
    .btn_o (time_button)
  );

  btn_debounce #(
    .BTN_DEBOUNCE(BTN_DEBOUNCE)
  ) u_alarm_btn (
    .clk_i (clock),
    .rst_ni(reset),
    .btn_i (alarm_button_raw),
    .btn_o (alarm_button)
  );

endmodule

// File: tb/tb_alarm_keypad_scanner.sv
// Bench for alarm_keypad_scanner: a physical keypad model driven from a table of presses, plus
// hand-written sequences for latency, hold/release, bounce, reset and button filtering.
module tb_alarm_keypad_scanner;

  localparam logic [3:0]  NoKey = 4'hA;
  // Pressed-key mask bit index is row*3 + col.
  localparam logic [11:0] K1 = 12'h001;
  localparam logic [11:0] K5 = 12'h010;
  localparam logic [11:0] K6 = 12'h020;
  localparam logic [11:0] K8 = 12'h080;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  row_sense;
  logic [2:0]  col_drive;
  logic        time_raw;
  logic        alarm_raw;
  logic [3:0]  key;
  logic        key_strobe;
  logic        time_button;
  logic        alarm_button;
  logic [11:0] pressed;

  int   total = 0;
  int   bad = 0;
  int   strobe_total = 0;
  int   strobe_dbl = 0;
  logic strobe_prev = 1'b0;

  typedef struct packed {
    logic [11:0] press;
    logic [3:0]  exp_key;
    logic [1:0]  exp_strobes;
  } vec_t;

  vec_t vecs [10];

  always #5 clock = ~clock;

  alarm_keypad_scanner #(
    .SCAN_DIV       (4),
    .DEBOUNCE_FRAMES(3),
    .BTN_DEBOUNCE   (8)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .row_sense       (row_sense),
    .col_drive       (col_drive),
    .time_button_raw (time_raw),
    .alarm_button_raw(alarm_raw),
    .key             (key),
    .key_strobe      (key_strobe),
    .time_button     (time_button),
    .alarm_button    (alarm_button)
  );

  // A pressed switch pulls its row low while its column is driven low.
  always_comb begin
    row_sense = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (pressed[r*3+c] && !col_drive[c]) row_sense[r] = 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    strobe_prev <= key_strobe;
    if (key_strobe) strobe_total <= strobe_total + 1;
    if (key_strobe && strobe_prev) strobe_dbl <= strobe_dbl + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Holds reset, checks reset values, then releases it on a falling edge (cycle 0 of a frame).
  task automatic do_reset();
    reset     = 1'b0;
    pressed   = '0;
    time_raw  = 1'b0;
    alarm_raw = 1'b0;
    repeat (3) @(negedge clock);
    check("reset col_drive", int'(col_drive), 32'h6);
    check("reset key", int'(key), 32'hA);
    check("reset key_strobe", int'(key_strobe), 0);
    reset = 1'b1;
  endtask

  initial begin
    int        base;
    int        lat;
    int        cnt;
    logic [2:0] exp_col;

    reset     = 1'b0;
    pressed   = '0;
    time_raw  = 1'b0;
    alarm_raw = 1'b0;

    vecs[0] = '{12'h010, 4'h5, 2'd1};  // 5
    vecs[1] = '{12'h200, 4'hA, 2'd0};  // *
    vecs[2] = '{12'h800, 4'hA, 2'd0};  // #
    vecs[3] = '{12'h400, 4'h0, 2'd1};  // 0
    vecs[4] = '{12'h021, 4'hA, 2'd0};  // 1 + 6, different rows and columns
    vecs[5] = '{12'h009, 4'hA, 2'd0};  // 1 + 4, same column
    vecs[6] = '{12'h100, 4'h9, 2'd1};  // 9
    vecs[7] = '{12'h004, 4'h3, 2'd1};  // 3
    vecs[8] = '{12'h003, 4'hA, 2'd0};  // 1 + 2, same row
    vecs[9] = '{12'h080, 4'h8, 2'd1};  // 8

    for (int i = 0; i < 10; i++) begin
      do_reset();
      base    = strobe_total;
      pressed = vecs[i].press;
      repeat (60) @(negedge clock);
      check($sformatf("vec%0d key", i), int'(key), int'(vecs[i].exp_key));
      check($sformatf("vec%0d strobes", i), strobe_total - base, int'(vecs[i].exp_strobes));
      pressed = '0;
      repeat (48) @(negedge clock);
      check($sformatf("vec%0d release key", i), int'(key), int'(NoKey));
      check($sformatf("vec%0d release strobes", i), strobe_total - base,
            int'(vecs[i].exp_strobes));
    end

    // Single key: latency window, held key, frame-aligned release.
    do_reset();
    base    = strobe_total;
    pressed = K5;
    lat     = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (lat == 0 && key == 4'h5) lat = n;
    end
    check_range("key5 press latency", lat, 24, 40);
    check("key5 strobe", strobe_total - base, 1);
    repeat (200) @(negedge clock);
    check("key5 held key", int'(key), 5);
    check("key5 held strobes", strobe_total - base, 1);
    pressed = '0;
    lat     = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (lat == 0 && key == NoKey) lat = n;
    end
    check_range("key5 release latency", lat, 24, 40);
    repeat (4) @(negedge clock);
    check("key5 release strobes", strobe_total - base, 1);

    // Multi-press then release of one key.
    do_reset();
    base    = strobe_total;
    pressed = K1 | K6;
    repeat (60) @(negedge clock);
    check("multi key", int'(key), int'(NoKey));
    check("multi strobes", strobe_total - base, 0);
    pressed = K1;
    lat     = 0;
    for (int n = 1; n <= 48; n++) begin
      @(negedge clock);
      if (lat == 0 && key == 4'h1) lat = n;
    end
    check_range("multi release6 latency", lat, 24, 48);
    repeat (4) @(negedge clock);
    check("multi release6 strobes", strobe_total - base, 1);

    // Bounce: key 8 toggles every 7 cycles, no three matching frames until it is held.
    do_reset();
    base = strobe_total;
    cnt  = 0;
    for (int n = 0; n < 102; n++) begin
      pressed = (n >= 2 && ((n - 2) % 14) < 7) ? K8 : 12'h000;
      if (key != NoKey) cnt++;
      @(negedge clock);
    end
    check("bounce cycles off nokey", cnt, 0);
    pressed = K8;
    lat     = 0;
    for (int n = 1; n <= 48; n++) begin
      @(negedge clock);
      if (lat == 0 && key == 4'h8) lat = n;
    end
    check_range("bounce hold latency", lat, 1, 48);
    repeat (40) @(negedge clock);
    check("bounce hold strobes", strobe_total - base, 1);

    // Asynchronous reset in mid-frame with a key and the alarm button held.
    do_reset();
    pressed   = K5;
    alarm_raw = 1'b1;
    repeat (50) @(negedge clock);
    check("pre-reset key", int'(key), 5);
    check("pre-reset alarm", int'(alarm_button), 1);
    #2 reset = 1'b0;
    #1;
    check("async reset col_drive", int'(col_drive), 32'h6);
    check("async reset key", int'(key), 32'hA);
    check("async reset strobe", int'(key_strobe), 0);
    check("async reset alarm", int'(alarm_button), 0);
    check("async reset time", int'(time_button), 0);
    @(negedge clock);
    pressed   = '0;
    alarm_raw = 1'b0;
    reset     = 1'b1;
    for (int n = 0; n <= 12; n++) begin
      exp_col = ((n % 12) < 4) ? 3'b110 : ((n % 12) < 8) ? 3'b101 : 3'b011;
      check($sformatf("col_drive cycle %0d", n), int'(col_drive), int'(exp_col));
      @(negedge clock);
    end

    // Buttons: short glitch rejected, clean edges delayed by exactly 10 cycles.
    do_reset();
    cnt = 0;
    for (int n = 0; n < 24; n++) begin
      time_raw = (n < 5);
      if (time_button) cnt++;
      @(negedge clock);
    end
    check("time glitch cycles high", cnt, 0);
    alarm_raw = 1'b1;
    repeat (9) @(negedge clock);
    check("alarm rise at 9", int'(alarm_button), 0);
    @(negedge clock);
    check("alarm rise at 10", int'(alarm_button), 1);
    repeat (15) @(negedge clock);
    alarm_raw = 1'b0;
    repeat (9) @(negedge clock);
    check("alarm fall at 9", int'(alarm_button), 1);
    @(negedge clock);
    check("alarm fall at 10", int'(alarm_button), 0);
    time_raw = 1'b1;
    repeat (10) @(negedge clock);
    check("time held at 10", int'(time_button), 1);

    @(negedge clock);
    check("strobe back-to-back", strobe_dbl, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
